scan_mux_reg: RTL and testbench

Parametrised, registered N-channel, W-bit multiplexer with a valid/ready output stage and three modes. In manual mode it selects a channel from `sel`. In scan mode it cycles through an enable mask with a programmable dwell time. In hold mode it freezes capture. It sits between the lab's switch/sensor input banks and display or serial consumers, and is the sequential successor to the fixed 8:1 combinational mux.

---
 rtl/mux_pkg.sv | 38 +++
 rtl/dwell_timer.sv | 43 ++++
 rtl/scan_mux_reg.sv | 122 ++++++++++++
 tb/tb_scan_mux_reg.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the scan multiplexer family.
//   mode_e        - encodings of the 2-bit mode input (11 behaves as HOLD)
//   next_enabled  - next set mask index above ptr, wrapping; ptr if mask empty
// Designs using next_enabled must have at most MAX_CH channels.
package mux_pkg;

    localparam int unsigned MAX_CH    = 64;
    localparam int unsigned MAX_SEL_W = 6;

    typedef enum logic [1:0] {
        MODE_MANUAL   = 2'b00,
        MODE_SCAN     = 2'b01,
        MODE_HOLD     = 2'b10,
        MODE_HOLD_ALT = 2'b11
    } mode_e;

    // Mask bits above the real channel count are zero, so wrapping modulo
    // MAX_CH finds the same index as wrapping modulo the channel count.
    function automatic logic [MAX_SEL_W-1:0] next_enabled(
        input logic [MAX_SEL_W-1:0] ptr,
        input logic [MAX_CH-1:0]    mask
    );
        logic [MAX_SEL_W-1:0] res;
        logic [MAX_SEL_W-1:0] idx;
        logic                 found;
        res   = ptr;
        found = 1'b0;
        for (int i = 1; i <= int'(MAX_CH); i++) begin
            idx = ptr + MAX_SEL_W'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: modulo-DWELL cycle counter for scan dwell.
//   clk, rst - clock, asynchronous active-high reset
//   clr      - force count to 0 (priority over hold)
//   hold     - freeze count
//   expire   - registered flag, high while the count sits at DWELL-1
module dwell_timer #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic expire
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next count: clear, hold, or advance with wrap at DWELL-1.
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (!hold) begin
            cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // expire is computed from the next count so it is a plain flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            expire <= 1'(DWELL == 1);
        end else begin
            cnt    <= cnt_nxt;
            expire <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/scan_mux_reg.sv
// scan_mux_reg: registered CHANNELS x WIDTH multiplexer with MANUAL, SCAN and
// HOLD modes and a valid/ready output stage.
//   clk, rst   - clock, asynchronous active-high reset
//   din        - packed channels, channel c at [c*WIDTH +: WIDTH]
//   sel        - manual channel select
//   mode       - 00 MANUAL, 01 SCAN, 10/11 HOLD
//   ch_mask    - channels visited in SCAN mode
//   out_data   - captured sample
//   out_ch     - channel index of out_data
//   out_valid  - out_data holds an unconsumed sample
//   out_ready  - consumer accepts the sample when out_valid is high
// CHANNELS must not exceed mux_pkg::MAX_CH.
module scan_mux_reg
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned DWELL    = 4,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel,
    input  logic [1:0]                mode,
    input  logic [CHANNELS-1:0]       ch_mask,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] chan [CHANNELS];
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] ptr_data;
    logic             ptr_en;
    logic             expire;
    logic             slot_free;
    logic             is_scan;
    logic             is_manual;
    logic             mask_any;
    logic             scan_exp;
    logic             capture;
    logic             advance;
    logic             tmr_hold;
    logic [WIDTH-1:0] cap_data;
    logic [SEL_W-1:0] cap_ch;

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
        assign chan[g] = din[g*WIDTH +: WIDTH];
    end

    // Channel lookups; an out-of-range sel yields zero data.
    always_comb begin
        sel_data = '0;
        ptr_data = '0;
        ptr_en   = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (sel == SEL_W'(c)) begin
                sel_data = chan[c];
            end
            if (ptr == SEL_W'(c)) begin
                ptr_data = chan[c];
                ptr_en   = ch_mask[c];
            end
        end
    end

    assign ptr_nxt = SEL_W'(next_enabled(MAX_SEL_W'(ptr), MAX_CH'(ch_mask)));

    // Capture / advance decisions for this edge.
    always_comb begin
        slot_free = !out_valid || out_ready;
        is_scan   = (mode == MODE_SCAN);
        is_manual = (mode == MODE_MANUAL);
        mask_any  = |ch_mask;
        scan_exp  = is_scan && mask_any && expire;
        capture   = slot_free && (is_manual || (scan_exp && ptr_en));
        // A disabled channel is skipped even while the output is stalled.
        advance   = scan_exp && (!ptr_en || slot_free);
        // Freeze the dwell on an empty mask or while a due capture waits.
        tmr_hold  = is_scan && (!mask_any || (expire && ptr_en && !slot_free));
        cap_data  = is_manual ? sel_data : ptr_data;
        cap_ch    = is_manual ? sel : ptr;
    end

    // Outside SCAN the counter is parked at 0, so entering SCAN starts a
    // fresh dwell and leaving it discards the partial one.
    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!is_scan),
        .hold   (tmr_hold),
        .expire (expire)
    );

    // Output register, handshake and scan pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            if (capture) begin
                out_data  <= cap_data;
                out_ch    <= cap_ch;
                out_valid <= 1'b1;
            end else if (slot_free) begin
                out_valid <= 1'b0;
            end
            if (advance) begin
                ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_scan_mux_reg.sv
module tb_scan_mux_reg;

    localparam int W  = 8;
    localparam int CH = 8;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH*W-1:0] din = '0;
    logic [2:0]    sel = '0;
    logic [1:0]    mode = 2'b10;
    logic [CH-1:0] ch_mask = '0;
    logic [W-1:0]  out_data;
    logic [2:0]    out_ch;
    logic          out_valid;
    logic          out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    scan_mux_reg #(.WIDTH(W), .CHANNELS(CH), .DWELL(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .sel       (sel),
        .mode      (mode),
        .ch_mask   (ch_mask),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] chv(input int c);
        return din[c*W +: W];
    endfunction

    function automatic int next_ch(input int p, input logic [CH-1:0] m);
        for (int i = 1; i <= CH; i++) begin
            if (m[(p + i) % CH]) return (p + i) % CH;
        end
        return p;
    endfunction

    // Behavioural model: elapsed edges within the current dwell window.
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    int           m_ch = 0;
    int           m_ptr = 0;
    int           m_el = 0;
    logic [1:0]   m_prev = 2'b10;

    task automatic model_step();
        logic         free;
        logic         cap;
        logic [W-1:0] cd;
        int           cc;
        free = !m_valid || out_ready;
        cap  = 1'b0;
        cd   = '0;
        cc   = 0;
        if (mode == 2'b00) begin
            cap = 1'b1;
            cc  = int'(sel);
            cd  = (cc < CH) ? chv(cc) : '0;
        end else if (mode == 2'b01) begin
            if (m_prev != 2'b01) m_el = 0;
            if (ch_mask != '0) begin
                if (m_el + 1 < DW) begin
                    m_el++;
                end else if (ch_mask[m_ptr]) begin
                    if (free) begin
                        cap   = 1'b1;
                        cd    = chv(m_ptr);
                        cc    = m_ptr;
                        m_ptr = next_ch(m_ptr, ch_mask);
                        m_el  = 0;
                    end else begin
                        m_el = DW - 1;
                    end
                end else begin
                    m_ptr = next_ch(m_ptr, ch_mask);
                    m_el  = 0;
                end
            end
        end
        m_prev = mode;
        if (cap && free) begin
            m_valid = 1'b1;
            m_data  = cd;
            m_ch    = cc;
        end else if (free) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_valid = 1'b0;
                m_data  = '0;
                m_ch    = 0;
                m_ptr   = 0;
                m_el    = 0;
                m_prev  = 2'b10;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle compare against the model, plus stall stability.
    logic         p_v = 1'b0;
    logic         p_r = 1'b0;
    logic [W-1:0] p_d = '0;
    logic [2:0]   p_c = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                p_v = 1'b0;
            end else begin
                chk("model_valid", out_valid, m_valid);
                chk("model_data", out_data, m_data);
                chk("model_ch", out_ch, m_ch);
                if (p_v && !p_r) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, p_d);
                    chk("stall_ch", out_ch, p_c);
                end
                p_v = out_valid;
                p_r = out_ready;
                p_d = out_data;
                p_c = out_ch;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic edges_to_valid(input int maxc, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!out_valid && n < maxc);
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic set_std_din();
        for (int c = 0; c < CH; c++) din[c*W +: W] = W'(8'h10 + c);
    endtask

    int n;
    int cap_ch [$];
    int cap_t  [$];

    initial begin
        set_std_din();
        repeat (2) cyc();
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_ch", out_ch, 0);
        rst = 1'b0;

        // MANUAL sweep
        mode = 2'b00;
        for (int s = 0; s < CH; s++) begin
            sel = 3'(s);
            cyc();
            chk("manual_data", out_data, 8'h10 + s);
            chk("manual_ch", out_ch, s);
            chk("manual_valid", out_valid, 1);
        end

        // SCAN order 0,2,5,7,0
        mode = 2'b10;
        repeat (2) cyc();
        chk("hold_drain", out_valid, 0);
        ch_mask = 8'b1010_0101;
        mode = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (out_valid) begin
                cap_ch.push_back(int'(out_ch));
                cap_t.push_back(i);
                chk("scan_data", out_data, 8'h10 + out_ch);
            end
        end
        chk("scan_count", cap_ch.size(), 5);
        if (cap_ch.size() == 5) begin
            chk("scan_ch0", cap_ch[0], 0);
            chk("scan_ch1", cap_ch[1], 2);
            chk("scan_ch2", cap_ch[2], 5);
            chk("scan_ch3", cap_ch[3], 7);
            chk("scan_ch4", cap_ch[4], 0);
            for (int i = 0; i < 5; i++) chk("scan_time", cap_t[i], 4 * (i + 1));
        end

        // SCAN stall, then capture on the first free cycle
        edges_to_valid(8, n);
        chk("stall_first_lat", n, 4);
        chk("stall_first_ch", out_ch, 2);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) din[5*W +: W] = 8'hA5;
            cyc();
            chk("stall_hold_ch", out_ch, 2);
            chk("stall_hold_v", out_valid, 1);
        end
        out_ready = 1'b1;
        cyc();
        chk("unstall_ch", out_ch, 5);
        chk("unstall_data", out_data, 8'hA5);
        chk("unstall_v", out_valid, 1);
        set_std_din();

        // Empty mask
        ch_mask = '0;
        for (int i = 0; i < 11; i++) begin
            cyc();
            chk("empty_mask_v", out_valid, 0);
        end

        // Single channel
        ch_mask = 8'b0000_1000;
        cap_t.delete();
        for (int i = 1; i <= 24; i++) begin
            cyc();
            if (out_valid) begin
                chk("single_ch", out_ch, 3);
                cap_t.push_back(i);
            end
        end
        chk("single_enough", int'(cap_t.size() >= 4), 1);
        for (int i = 1; i < cap_t.size(); i++) chk("single_gap", cap_t[i] - cap_t[i-1], DW);

        // HOLD with pending sample
        out_ready = 1'b0;
        cyc();
        chk("pend_v", out_valid, 1);
        mode = 2'b10;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold_pend_v", out_valid, 1);
            chk("hold_pend_ch", out_ch, 3);
        end
        out_ready = 1'b1;
        cyc();
        chk("hold_accept_v", out_valid, 0);
        mode = 2'b01;
        edges_to_valid(10, n);
        chk("rescan_lat", n, DW);
        chk("rescan_ch", out_ch, 3);

        // Reset mid-stall
        ch_mask = 8'hFF;
        out_ready = 1'b0;
        edges_to_valid(10, n);
        repeat (2) cyc();
        rst = 1'b1;
        #1;
        chk("rst_stall_v", out_valid, 0);
        chk("rst_stall_d", out_data, 0);
        chk("rst_stall_c", out_ch, 0);
        repeat (2) cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        edges_to_valid(10, n);
        chk("rst_resume_lat", n, DW);
        chk("rst_resume_ch", out_ch, 0);
        chk("rst_resume_d", out_data, 8'h10);

        // Reset mid-dwell
        repeat (2) cyc();
        rst = 1'b1;
        #1;
        chk("rst_dwell_v", out_valid, 0);
        chk("rst_dwell_c", out_ch, 0);
        cyc();
        rst = 1'b0;
        edges_to_valid(10, n);
        chk("rst_dwell_lat", n, DW);
        chk("rst_dwell_ch", out_ch, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) begin
                case ($urandom_range(3))
                    0: ch_mask = '0;
                    1: ch_mask = CH'(1) << $urandom_range(CH - 1);
                    default: ch_mask = CH'($urandom);
                endcase
            end
            out_ready = ($urandom_range(3) != 0);
            sel = 3'($urandom_range(CH - 1));
            for (int c = 0; c < CH; c++) din[c*W +: W] = W'($urandom);
            rst = ($urandom_range(499) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
